lc3b_fetch_stage: RTL and testbench

Instruction fetch stage of the pipelined LC-3b: owns the fetch PC, issues word reads to the L1 instruction cache, buffers returned instructions in a small FIFO, and presents them with their PC to the decode stage via a valid/ready handshake. Redirects from execute (branch, JMP/RET, JSR/JSRR, TRAP) flush the buffer and restart fetch at the new PC. It sits between the I-cache port and the IF/ID boundary.

---
 rtl/lc3b_fetch_stage_pkg.sv | 25 ++
 rtl/lc3b_fetch_stage_fifo.sv | 85 ++++++++
 rtl/lc3b_fetch_stage.sv | 140 ++++++++++++++
 tb/tb_lc3b_fetch_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_fetch_stage_pkg.sv
// Shared types and constants for the LC-3b instruction fetch stage.
package lc3b_fetch_stage_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    fetch_req     = 2'd0,
    fetch_hold    = 2'd1,
    fetch_discard = 2'd2
  } lc3b_fetch_state;

  localparam lc3b_word LC3B_RESET_PC = 16'h0000;
  localparam lc3b_word LC3B_PC_STEP  = 16'h0002;

  // Next sequential word address; wraps naturally at 16 bits.
  function automatic lc3b_word pc_plus2(input lc3b_word pc);
    return pc + LC3B_PC_STEP;
  endfunction

  // Force a word address onto an even byte boundary.
  function automatic lc3b_word word_align(input lc3b_word pc);
    return pc & 16'hFFFE;
  endfunction

endpackage

// File: rtl/lc3b_fetch_stage_fifo.sv
// Small circular buffer of fetched {pc, instr} pairs between I-cache and decode.
module lc3b_fetch_fifo
  import lc3b_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  lc3b_word       push_pc,
  input  lc3b_word       push_instr,
  output lc3b_word       head_pc,
  output lc3b_word       head_instr,
  output logic [CW-1:0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  lc3b_word      pc_q    [DEPTH];
  lc3b_word      pc_d    [DEPTH];
  lc3b_word      instr_q [DEPTH];
  lc3b_word      instr_d [DEPTH];

  // Next-state for pointers, occupancy and storage; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]    = push_pc;
        instr_d[wr_ptr_q] = push_instr;
        wr_ptr_d          = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= 16'h0000;
        instr_q[i] <= 16'h0000;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
    end
  end

  assign head_pc    = pc_q[rd_ptr_q];
  assign head_instr = instr_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/lc3b_fetch_stage.sv
// LC-3b fetch stage: fetch PC, I-cache request FSM, fetch buffer and IF/ID handshake.
module lc3b_fetch_stage
  import lc3b_fetch_stage_pkg::*;
#(
  parameter lc3b_word RESET_PC = LC3B_RESET_PC,
  parameter int       DEPTH    = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  output logic     imem_read,
  output lc3b_word imem_address,
  input  lc3b_word imem_rdata,
  input  logic     imem_resp,
  input  logic     redirect_valid,
  input  lc3b_word redirect_pc,
  output logic     if_valid,
  input  logic     if_ready,
  output lc3b_word if_instr,
  output lc3b_word if_pc,
  output lc3b_word if_pc_plus2
);

  localparam int CW = $clog2(DEPTH) + 1;

  lc3b_fetch_state state_q, state_d;
  lc3b_word        fetch_pc_q, fetch_pc_d;
  lc3b_word        imem_address_q, imem_address_d;
  logic            imem_read_q, imem_read_d;

  logic            push_s;
  logic            pop_s;
  logic            nonempty_s;
  logic [CW-1:0]   count_s;
  lc3b_word        head_pc_s;
  lc3b_word        head_instr_s;
  lc3b_word        target_pc_s;

  assign target_pc_s = word_align(redirect_pc);
  assign nonempty_s  = (count_s != CW'(0));
  assign if_valid    = nonempty_s & ~redirect_valid;
  assign pop_s       = if_valid & if_ready;

  lc3b_fetch_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .push_pc    (fetch_pc_q),
    .push_instr (imem_rdata),
    .head_pc    (head_pc_s),
    .head_instr (head_instr_s),
    .count      (count_s)
  );

  // Fetch FSM next state, fetch PC update and buffer push decision.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push_s     = 1'b0;
    case (state_q)
      fetch_req: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc_s;
          // An in-flight request cannot be withdrawn, so its data must be dropped.
          state_d    = imem_resp ? fetch_req : fetch_discard;
        end else if (imem_resp) begin
          push_s     = 1'b1;
          fetch_pc_d = pc_plus2(fetch_pc_q);
          // A simultaneous pop frees the slot this push would otherwise fill.
          if (pop_s || ((count_s + CW'(1)) < CW'(DEPTH))) begin
            state_d = fetch_req;
          end else begin
            state_d = fetch_hold;
          end
        end else begin
          state_d = fetch_req;
        end
      end
      fetch_hold: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc_s;
          state_d    = fetch_req;
        end else if (pop_s) begin
          state_d = fetch_req;
        end else begin
          state_d = fetch_hold;
        end
      end
      fetch_discard: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (imem_resp) begin
          state_d = fetch_req;
        end else begin
          state_d = fetch_discard;
        end
      end
      default: begin
        state_d    = fetch_req;
        fetch_pc_d = fetch_pc_q;
      end
    endcase
  end

  // Registered I-cache request: address is frozen while a stale request drains.
  always_comb begin
    imem_read_d = (state_d != fetch_hold);
    if (state_d == fetch_discard) begin
      imem_address_d = imem_address_q;
    end else begin
      imem_address_d = fetch_pc_d;
    end
  end

  // FSM state, fetch PC and registered memory request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= fetch_req;
      fetch_pc_q     <= RESET_PC;
      imem_read_q    <= 1'b0;
      imem_address_q <= RESET_PC;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      imem_read_q    <= imem_read_d;
      imem_address_q <= imem_address_d;
    end
  end

  assign imem_read    = imem_read_q;
  assign imem_address = imem_address_q;
  assign if_instr     = nonempty_s ? head_instr_s : 16'h0000;
  assign if_pc        = nonempty_s ? head_pc_s : 16'h0000;
  assign if_pc_plus2  = nonempty_s ? pc_plus2(head_pc_s) : 16'h0000;

endmodule

// File: tb/tb_lc3b_fetch_stage.sv
// Directed testbench for lc3b_fetch_stage with a variable-latency memory model.
module tb_lc3b_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;

  int total;
  int bad;
  int mem_lat;
  int mem_wait;

  lc3b_fetch_stage #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    else if (a == 16'h0002) return 16'h5678;
    else return a ^ 16'hA5A5;
  endfunction

  // Memory model: response in the mem_lat-th cycle a request is seen.
  task automatic mem_drive();
    if (imem_read) begin
      if (mem_wait + 1 >= mem_lat) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(imem_address);
        mem_wait   = 0;
      end else begin
        imem_resp  = 1'b0;
        imem_rdata = 16'h0000;
        mem_wait   = mem_wait + 1;
      end
    end else begin
      imem_resp  = 1'b0;
      imem_rdata = 16'h0000;
      mem_wait   = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mem_drive();
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    imem_resp      = 1'b0;
    imem_rdata     = 16'h0000;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    if_ready       = 1'b0;
    mem_wait       = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL rst_read got=%h exp=0", imem_read); end
    total++; if (imem_address !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", imem_address); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", if_valid); end
    total++; if (if_instr !== 16'h0000) begin bad++; $display("FAIL rst_instr got=%h exp=0000", if_instr); end
    total++; if (if_pc !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=0000", if_pc); end
    total++; if (if_pc_plus2 !== 16'h0000) begin bad++; $display("FAIL rst_pc2 got=%h exp=0000", if_pc_plus2); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL rst_rel_read got=%h exp=1", imem_read); end
    total++; if (imem_address !== 16'h0000) begin bad++; $display("FAIL rst_rel_addr got=%h exp=0000", imem_address); end
  endtask

  task automatic test_stream();
    mem_lat = 1;
    apply_reset();
    step();
    total++; if (imem_address !== 16'h0000) begin bad++; $display("FAIL str_addr0 got=%h exp=0000", imem_address); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL str_valid0 got=%h exp=0", if_valid); end
    step();
    total++; if (imem_address !== 16'h0002) begin bad++; $display("FAIL str_addr1 got=%h exp=0002", imem_address); end
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL str_valid1 got=%h exp=1", if_valid); end
    total++; if (if_pc !== 16'h0000) begin bad++; $display("FAIL str_pc1 got=%h exp=0000", if_pc); end
    total++; if (if_instr !== 16'h1234) begin bad++; $display("FAIL str_instr1 got=%h exp=1234", if_instr); end
    total++; if (if_pc_plus2 !== 16'h0002) begin bad++; $display("FAIL str_pc2_1 got=%h exp=0002", if_pc_plus2); end
    if_ready = 1'b1;
    step();
    total++; if (imem_address !== 16'h0004) begin bad++; $display("FAIL str_addr2 got=%h exp=0004", imem_address); end
    total++; if (if_pc !== 16'h0002) begin bad++; $display("FAIL str_pc2 got=%h exp=0002", if_pc); end
    total++; if (if_instr !== 16'h5678) begin bad++; $display("FAIL str_instr2 got=%h exp=5678", if_instr); end
    total++; if (if_pc_plus2 !== 16'h0004) begin bad++; $display("FAIL str_pc2_2 got=%h exp=0004", if_pc_plus2); end
    if_ready = 1'b0;
  endtask

  task automatic test_hold();
    mem_lat = 1;
    apply_reset();
    step();
    step();
    step();
    total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL hold_read got=%h exp=0", imem_read); end
    total++; if (if_pc !== 16'h0000) begin bad++; $display("FAIL hold_pc got=%h exp=0000", if_pc); end
    step();
    total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL hold_read2 got=%h exp=0", imem_read); end
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%h exp=1", if_valid); end
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL hold_reread got=%h exp=1", imem_read); end
    total++; if (imem_address !== 16'h0004) begin bad++; $display("FAIL hold_addr got=%h exp=0004", imem_address); end
    total++; if (if_pc !== 16'h0002) begin bad++; $display("FAIL hold_pc2 got=%h exp=0002", if_pc); end
  endtask

  task automatic test_discard();
    mem_lat = 3;
    apply_reset();
    if_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h3001;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_address !== 16'h0000) begin bad++; $display("FAIL dis_addr_hold got=%h exp=0000", imem_address); end
    total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL dis_read got=%h exp=1", imem_read); end
    step();
    step();
    total++; if (imem_address !== 16'h3000) begin bad++; $display("FAIL dis_addr_new got=%h exp=3000", imem_address); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL dis_dropped got=%h exp=0", if_valid); end
    repeat (3) step();
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL dis_valid got=%h exp=1", if_valid); end
    total++; if (if_pc !== 16'h3000) begin bad++; $display("FAIL dis_pc got=%h exp=3000", if_pc); end
    total++; if (if_instr !== (16'h3000 ^ 16'hA5A5)) begin bad++; $display("FAIL dis_instr got=%h exp=%h", if_instr, 16'h3000 ^ 16'hA5A5); end
    if_ready = 1'b0;
  endtask

  task automatic test_redirect_coincident();
    mem_lat = 1;
    apply_reset();
    step();
    step();
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL coin_forced got=%h exp=0", if_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    total++; if (imem_address !== 16'h0100) begin bad++; $display("FAIL coin_addr got=%h exp=0100", imem_address); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL coin_flushed got=%h exp=0", if_valid); end
    if_ready = 1'b0;
    step();
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL coin_valid got=%h exp=1", if_valid); end
    total++; if (if_pc !== 16'h0100) begin bad++; $display("FAIL coin_pc got=%h exp=0100", if_pc); end
    total++; if (if_instr !== 16'hA4A5) begin bad++; $display("FAIL coin_instr got=%h exp=a4a5", if_instr); end
  endtask

  task automatic test_wrap();
    mem_lat = 1;
    apply_reset();
    if_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_address !== 16'hFFFE) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffe", imem_address); end
    step();
    total++; if (imem_address !== 16'h0000) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0000", imem_address); end
    total++; if (if_pc !== 16'hFFFE) begin bad++; $display("FAIL wrap_pc got=%h exp=fffe", if_pc); end
    total++; if (if_pc_plus2 !== 16'h0000) begin bad++; $display("FAIL wrap_pc2 got=%h exp=0000", if_pc_plus2); end
    step();
    total++; if (if_pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc_b got=%h exp=0000", if_pc); end
    total++; if (if_pc_plus2 !== 16'h0002) begin bad++; $display("FAIL wrap_pc2_b got=%h exp=0002", if_pc_plus2); end
    if_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    mem_lat = 3;
    apply_reset();
    repeat (4) step();
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL ares_pre_valid got=%h exp=1", if_valid); end
    total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL ares_pre_read got=%h exp=1", imem_read); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL ares_read got=%h exp=0", imem_read); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL ares_valid got=%h exp=0", if_valid); end
    total++; if (imem_address !== 16'h0000) begin bad++; $display("FAIL ares_addr got=%h exp=0000", imem_address); end
    @(negedge clk);
    imem_resp  = 1'b0;
    imem_rdata = 16'h0000;
    mem_wait   = 0;
    rst_n      = 1'b1;
    step();
    total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL ares_rel_read got=%h exp=1", imem_read); end
    total++; if (imem_address !== 16'h0000) begin bad++; $display("FAIL ares_rel_addr got=%h exp=0000", imem_address); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL ares_rel_valid got=%h exp=0", if_valid); end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    mem_lat        = 1;
    mem_wait       = 0;
    rst_n          = 1'b0;
    imem_resp      = 1'b0;
    imem_rdata     = 16'h0000;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    if_ready       = 1'b0;
    test_reset();
    test_stream();
    test_hold();
    test_discard();
    test_redirect_coincident();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
